// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM encoding, field widths and playfield constants
// used by both the ball position and velocity blocks.
package pong_pkg;

  localparam int X_W     = 7;
  localparam int Y_W     = 6;
  localparam int SCORE_W = 4;
  localparam int VEL_W   = 3;

  localparam logic [X_W-1:0]     X_CENTER_DEF  = 7'd64;
  localparam logic [Y_W-1:0]     Y_CENTER_DEF  = 6'd32;
  localparam logic [X_W-1:0]     X_MIN_DEF     = 7'd2;
  localparam logic [X_W-1:0]     X_MAX_DEF     = 7'd125;
  localparam logic [SCORE_W-1:0] WIN_SCORE_DEF = 4'd9;
  localparam int unsigned        GOAL_WAIT_DEF = 60;

  // Velocity the companion block holds while vel_rst is asserted.
  localparam logic signed [VEL_W-1:0] DX_SERVE = 3'sd0;
  localparam logic signed [VEL_W-1:0] DY_SERVE = -3'sd1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    GOAL_WAIT = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                 input logic [SCORE_W-1:0] limit);
    logic [SCORE_W-1:0] result;
    result = value;
    if (value < limit) begin
      result = value + SCORE_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/score_counter.sv
// Per-player score register: increments on a goal, saturates at the winning
// score, and clears when a new match starts.
module score_counter
  import pong_pkg::*;
#(
  parameter logic [SCORE_W-1:0] MAX = WIN_SCORE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc_i,
  input  logic               clear_i,
  output logic [SCORE_W-1:0] count_o
);

  logic [SCORE_W-1:0] count_q;
  logic [SCORE_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = sat_inc(count_q, MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ball_position.sv
// Ball position and match control for Pong: moves the ball on frame ticks,
// detects goals at the top/bottom edges and sequences serve, wait and game over.
module ball_position
  import pong_pkg::*;
#(
  parameter logic [SCORE_W-1:0] WIN_SCORE       = WIN_SCORE_DEF,
  parameter int unsigned        GOAL_WAIT_TICKS = GOAL_WAIT_DEF,
  parameter logic [X_W-1:0]     X_CENTER        = X_CENTER_DEF,
  parameter logic [Y_W-1:0]     Y_CENTER        = Y_CENTER_DEF,
  parameter logic [X_W-1:0]     X_MIN           = X_MIN_DEF,
  parameter logic [X_W-1:0]     X_MAX           = X_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    move_tick,
  input  logic signed [VEL_W-1:0] dx,
  input  logic signed [VEL_W-1:0] dy,
  input  logic                    serve_btn,
  output logic [X_W-1:0]          ballX,
  output logic [Y_W-1:0]          ballY,
  output logic                    vel_rst,
  output logic [SCORE_W-1:0]      score_top,
  output logic [SCORE_W-1:0]      score_bottom,
  output logic                    goal_top,
  output logic                    goal_bottom,
  output logic                    game_over
);

  localparam int WAIT_W = (GOAL_WAIT_TICKS < 2) ? 1 : $clog2(GOAL_WAIT_TICKS + 1);

  state_e              state_q, state_d;
  logic [X_W-1:0]      ballX_q, ballX_d;
  logic [Y_W-1:0]      ballY_q, ballY_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                velRst_q, velRst_d;
  logic                goalTop_q, goalTop_d;
  logic                goalBottom_q, goalBottom_d;
  logic                gameOver_q, gameOver_d;

  logic                incTop, incBottom, clearScores;
  logic [SCORE_W-1:0]  scoreTop, scoreBottom;

  logic signed [X_W+1:0] nextX;
  logic signed [Y_W+1:0] nextY;
  logic [X_W-1:0]        clampedX;
  logic                  pastBottom, pastTop;
  logic                  matchWon;

  // Candidate position for this tick; widened so under/overflow stays visible.
  always_comb begin
    nextX = $signed({2'b00, ballX_q} + {{(X_W-1){dx[VEL_W-1]}}, dx});
    nextY = $signed({2'b00, ballY_q} + {{(Y_W-1){dy[VEL_W-1]}}, dy});

    clampedX = nextX[X_W-1:0];
    if (nextX < $signed({2'b00, X_MIN})) begin
      clampedX = X_MIN;
    end else if (nextX > $signed({2'b00, X_MAX})) begin
      clampedX = X_MAX;
    end

    pastBottom = nextY[Y_W+1];
    pastTop    = nextY > $signed({2'b00, {Y_W{1'b1}}});
    matchWon   = (scoreTop == WIN_SCORE) || (scoreBottom == WIN_SCORE);
  end

  always_comb begin
    state_d      = state_q;
    ballX_d      = ballX_q;
    ballY_d      = ballY_q;
    wait_d       = wait_q;
    goalTop_d    = 1'b0;
    goalBottom_d = 1'b0;
    incTop       = 1'b0;
    incBottom    = 1'b0;
    clearScores  = 1'b0;

    case (state_q)
      IDLE: begin
        ballX_d = X_CENTER;
        ballY_d = Y_CENTER;
        if (serve_btn) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (move_tick) begin
          ballX_d = clampedX;
          if (pastBottom) begin
            incBottom    = 1'b1;
            goalBottom_d = 1'b1;
            wait_d       = WAIT_W'(GOAL_WAIT_TICKS);
            state_d      = GOAL_WAIT;
          end else if (pastTop) begin
            incTop    = 1'b1;
            goalTop_d = 1'b1;
            wait_d    = WAIT_W'(GOAL_WAIT_TICKS);
            state_d   = GOAL_WAIT;
          end else begin
            ballY_d = nextY[Y_W-1:0];
          end
        end
      end

      GOAL_WAIT: begin
        // Leave on the tick that takes the counter to zero, or at once if it is already zero.
        if ((wait_q == '0) || (move_tick && (wait_q == WAIT_W'(1)))) begin
          wait_d  = '0;
          ballX_d = X_CENTER;
          ballY_d = Y_CENTER;
          state_d = matchWon ? GAME_OVER : IDLE;
        end else if (move_tick) begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      GAME_OVER: begin
        ballX_d = X_CENTER;
        ballY_d = Y_CENTER;
        if (serve_btn) begin
          clearScores = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    velRst_d   = (state_d != PLAY);
    gameOver_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ballX_q      <= X_CENTER;
      ballY_q      <= Y_CENTER;
      wait_q       <= '0;
      velRst_q     <= 1'b1;
      goalTop_q    <= 1'b0;
      goalBottom_q <= 1'b0;
      gameOver_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ballX_q      <= ballX_d;
      ballY_q      <= ballY_d;
      wait_q       <= wait_d;
      velRst_q     <= velRst_d;
      goalTop_q    <= goalTop_d;
      goalBottom_q <= goalBottom_d;
      gameOver_q   <= gameOver_d;
    end
  end

  score_counter #(.MAX(WIN_SCORE)) u_scoreTop (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (incTop),
    .clear_i (clearScores),
    .count_o (scoreTop)
  );

  score_counter #(.MAX(WIN_SCORE)) u_scoreBottom (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (incBottom),
    .clear_i (clearScores),
    .count_o (scoreBottom)
  );

  assign ballX        = ballX_q;
  assign ballY        = ballY_q;
  assign vel_rst      = velRst_q;
  assign score_top    = scoreTop;
  assign score_bottom = scoreBottom;
  assign goal_top     = goalTop_q;
  assign goal_bottom  = goalBottom_q;
  assign game_over    = gameOver_q;

endmodule

// File: tb/tb_ball_position.sv
// Self-checking bench for ball_position: directed scenarios against fixed
// values plus a randomized run against a behavioural match model.
module tb_ball_position;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              move_tick = 1'b0;
  logic signed [2:0] dx = 3'sd0;
  logic signed [2:0] dy = 3'sd0;
  logic              serve_btn = 1'b0;
  logic [6:0]        ballX;
  logic [5:0]        ballY;
  logic              vel_rst;
  logic [3:0]        score_top, score_bottom;
  logic              goal_top, goal_bottom, game_over;

  int compared = 0;
  int mismatched = 0;

  localparam int M_IDLE = 0, M_PLAY = 1, M_WAIT = 2, M_OVER = 3;
  int mState = M_IDLE, mX = 64, mY = 32, mScoreT = 0, mScoreB = 0, mWait = 0;
  bit mGoalT = 0, mGoalB = 0;

  ball_position dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .move_tick    (move_tick),
    .dx           (dx),
    .dy           (dy),
    .serve_btn    (serve_btn),
    .ballX        (ballX),
    .ballY        (ballY),
    .vel_rst      (vel_rst),
    .score_top    (score_top),
    .score_bottom (score_bottom),
    .goal_top     (goal_top),
    .goal_bottom  (goal_bottom),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  // Match rules applied to one clock edge with the inputs currently driven.
  function automatic void modelStep();
    int nx, ny;
    mGoalT = 0;
    mGoalB = 0;
    if (rst_n == 1'b0) begin
      mState = M_IDLE; mX = 64; mY = 32; mScoreT = 0; mScoreB = 0; mWait = 0;
    end else begin
      case (mState)
        M_IDLE: begin
          mX = 64; mY = 32;
          if (serve_btn) mState = M_PLAY;
        end
        M_PLAY: if (move_tick) begin
          nx = mX + int'(dx);
          ny = mY + int'(dy);
          if (nx < 2) nx = 2;
          if (nx > 125) nx = 125;
          mX = nx;
          if (ny < 0) begin
            mScoreB = (mScoreB < 9) ? mScoreB + 1 : 9;
            mGoalB = 1; mWait = 60; mState = M_WAIT;
          end else if (ny > 63) begin
            mScoreT = (mScoreT < 9) ? mScoreT + 1 : 9;
            mGoalT = 1; mWait = 60; mState = M_WAIT;
          end else begin
            mY = ny;
          end
        end
        M_WAIT: if (move_tick) begin
          mWait = mWait - 1;
          if (mWait == 0) begin
            mX = 64; mY = 32;
            mState = (mScoreT == 9 || mScoreB == 9) ? M_OVER : M_IDLE;
          end
        end
        default: begin
          mX = 64; mY = 32;
          if (serve_btn) begin
            mScoreT = 0; mScoreB = 0; mState = M_IDLE;
          end
        end
      endcase
    end
  endfunction

  task automatic applyStimulus(input bit r, input bit s, input bit t, input int dxi, input int dyi);
    rst_n = r;
    serve_btn = s;
    move_tick = t;
    dx = 3'(dxi);
    dy = 3'(dyi);
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic runTicks(input int n, input int dxi, input int dyi);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1, 0, 1, dxi, dyi);
      cycle();
    end
  endtask

  task automatic test_reset();
    applyStimulus(0, 1, 1, 2, 1);
    cycle();
    cycle();
    compared++;
    if (ballX !== 7'd64 || ballY !== 6'd32) begin
      mismatched++;
      $display("[TB] FAIL reset_ball: got (%0d,%0d) want (64,32)", ballX, ballY);
    end
    compared++;
    if ({vel_rst, game_over, goal_top, goal_bottom} !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got vel/go/gt/gb=%b want 1000", {vel_rst, game_over, goal_top, goal_bottom});
    end
    compared++;
    if (score_top !== 4'd0 || score_bottom !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_scores: got %0d/%0d want 0/0", score_top, score_bottom);
    end
  endtask

  task automatic test_serve();
    applyStimulus(1, 0, 1, 2, 1);
    cycle();
    compared++;
    if (vel_rst !== 1'b1 || ballX !== 7'd64 || ballY !== 6'd32) begin
      mismatched++;
      $display("[TB] FAIL idle_hold: got vel_rst=%0d ball=(%0d,%0d) want 1 (64,32)", vel_rst, ballX, ballY);
    end
    applyStimulus(1, 1, 1, 2, 1);
    cycle();
    compared++;
    if (vel_rst !== 1'b0 || ballX !== 7'd64 || ballY !== 6'd32) begin
      mismatched++;
      $display("[TB] FAIL serve: got vel_rst=%0d ball=(%0d,%0d) want 0 (64,32)", vel_rst, ballX, ballY);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 2, 1);
      cycle();
    end
    compared++;
    if (ballX !== 7'd64 || ballY !== 6'd32 || vel_rst !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL no_tick_hold: got ball=(%0d,%0d) vel_rst=%0d want (64,32) 0", ballX, ballY, vel_rst);
    end
  endtask

  task automatic test_motion();
    runTicks(3, 2, 1);
    applyStimulus(1, 1, 0, -2, -1);
    cycle();
    compared++;
    if (ballX !== 7'd70 || ballY !== 6'd35) begin
      mismatched++;
      $display("[TB] FAIL motion: got (%0d,%0d) want (70,35)", ballX, ballY);
    end
  endtask

  task automatic test_clamp();
    runTicks(27, 2, 0);
    compared++;
    if (ballX !== 7'd124) begin
      mismatched++;
      $display("[TB] FAIL walk_right: got ballX=%0d want 124", ballX);
    end
    runTicks(1, 2, 0);
    compared++;
    if (ballX !== 7'd125 || ballY !== 6'd35) begin
      mismatched++;
      $display("[TB] FAIL clamp_max: got (%0d,%0d) want (125,35)", ballX, ballY);
    end
    runTicks(61, -2, 0);
    compared++;
    if (ballX !== 7'd3) begin
      mismatched++;
      $display("[TB] FAIL walk_left: got ballX=%0d want 3", ballX);
    end
    runTicks(1, -2, 0);
    compared++;
    if (ballX !== 7'd2) begin
      mismatched++;
      $display("[TB] FAIL clamp_min: got ballX=%0d want 2", ballX);
    end
  endtask

  task automatic test_goal_bottom();
    runTicks(35, 0, -1);
    compared++;
    if (ballY !== 6'd0 || goal_bottom !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reach_bottom: got ballY=%0d goal_bottom=%0d want 0 0", ballY, goal_bottom);
    end
    runTicks(1, 0, -1);
    compared++;
    if ({goal_bottom, goal_top, vel_rst} !== 3'b101 || score_bottom !== 4'd1 || ballY !== 6'd0 || ballX !== 7'd2) begin
      mismatched++;
      $display("[TB] FAIL goal_bottom: got gb/gt/vr=%b score=%0d ball=(%0d,%0d) want 101 1 (2,0)",
               {goal_bottom, goal_top, vel_rst}, score_bottom, ballX, ballY);
    end
    applyStimulus(1, 1, 0, 0, -1);
    cycle();
    compared++;
    if (goal_bottom !== 1'b0 || score_bottom !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL goal_pulse_width: got goal_bottom=%0d score=%0d want 0 1", goal_bottom, score_bottom);
    end
    for (int i = 0; i < 59; i++) begin
      applyStimulus(1, 1'($urandom_range(0, 1)), 1, 0, -1);
      cycle();
    end
    compared++;
    if (ballX !== 7'd2 || ballY !== 6'd0 || vel_rst !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wait_59: got ball=(%0d,%0d) vel_rst=%0d want (2,0) 1", ballX, ballY, vel_rst);
    end
    runTicks(1, 0, -1);
    compared++;
    if (ballX !== 7'd64 || ballY !== 6'd32 || vel_rst !== 1'b1 || game_over !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wait_done: got ball=(%0d,%0d) vel_rst=%0d game_over=%0d want (64,32) 1 0",
               ballX, ballY, vel_rst, game_over);
    end
  endtask

  task automatic scoreTop();
    applyStimulus(1, 1, 0, 0, 1);
    cycle();
    runTicks(32, 0, 1);
    runTicks(60, 0, 1);
  endtask

  task automatic test_game_over();
    for (int g = 0; g < 8; g++) scoreTop();
    compared++;
    if (score_top !== 4'd8 || score_bottom !== 4'd1 || game_over !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL eight_goals: got top=%0d bottom=%0d game_over=%0d want 8 1 0", score_top, score_bottom, game_over);
    end
    applyStimulus(1, 1, 0, 0, 1);
    cycle();
    runTicks(31, 0, 1);
    compared++;
    if (ballY !== 6'd63) begin
      mismatched++;
      $display("[TB] FAIL reach_top: got ballY=%0d want 63", ballY);
    end
    runTicks(1, 0, 1);
    compared++;
    if (score_top !== 4'd9 || goal_top !== 1'b1 || goal_bottom !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL winning_goal: got top=%0d goal_top=%0d goal_bottom=%0d want 9 1 0", score_top, goal_top, goal_bottom);
    end
    runTicks(60, 0, 1);
    compared++;
    if (game_over !== 1'b1 || vel_rst !== 1'b1 || ballX !== 7'd64 || ballY !== 6'd32) begin
      mismatched++;
      $display("[TB] FAIL game_over: got game_over=%0d vel_rst=%0d ball=(%0d,%0d) want 1 1 (64,32)",
               game_over, vel_rst, ballX, ballY);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 1'($urandom_range(0, 1)), 2, 1);
      cycle();
    end
    compared++;
    if (game_over !== 1'b1 || score_top !== 4'd9 || score_bottom !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL over_hold: got game_over=%0d scores=%0d/%0d want 1 9/1", game_over, score_top, score_bottom);
    end
    applyStimulus(1, 1, 0, 0, 0);
    cycle();
    compared++;
    if (game_over !== 1'b0 || score_top !== 4'd0 || score_bottom !== 4'd0 || vel_rst !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL restart: got game_over=%0d scores=%0d/%0d vel_rst=%0d want 0 0/0 1",
               game_over, score_top, score_bottom, vel_rst);
    end
    applyStimulus(1, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic test_reset_mid_wait();
    bit sawGoal;
    applyStimulus(1, 1, 0, 0, -1);
    cycle();
    runTicks(33, 0, -1);
    compared++;
    if (score_bottom !== 4'd1 || goal_bottom !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_goal: got score_bottom=%0d goal_bottom=%0d want 1 1", score_bottom, goal_bottom);
    end
    runTicks(10, 0, -1);
    applyStimulus(0, 1, 1, 2, -1);
    cycle();
    compared++;
    if (score_bottom !== 4'd0 || score_top !== 4'd0 || goal_bottom !== 1'b0 || goal_top !== 1'b0 ||
        ballX !== 7'd64 || ballY !== 6'd32 || vel_rst !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_wait: got scores=%0d/%0d goals=%b ball=(%0d,%0d) vel_rst=%0d want 0/0 00 (64,32) 1",
               score_top, score_bottom, {goal_top, goal_bottom}, ballX, ballY, vel_rst);
    end
    sawGoal = 0;
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1, 0, 1, 0, -1);
      cycle();
      sawGoal |= goal_bottom | goal_top;
    end
    compared++;
    if (sawGoal !== 1'b0 || vel_rst !== 1'b1 || ballY !== 6'd32) begin
      mismatched++;
      $display("[TB] FAIL post_reset_idle: got goal_seen=%0d vel_rst=%0d ballY=%0d want 0 1 32", sawGoal, vel_rst, ballY);
    end
  endtask

  task automatic test_random();
    logic [25:0] got, want;
    applyStimulus(0, 0, 0, 0, 0);
    cycle();
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 599) != 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)) - 1);
      cycle();
      got  = {ballX, ballY, vel_rst, score_top, score_bottom, goal_top, goal_bottom, game_over};
      want = {7'(mX), 6'(mY), mState != M_PLAY, 4'(mScoreT), 4'(mScoreB), mGoalT, mGoalB, mState == M_OVER};
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL random_cycle_%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_motion();
    test_clamp();
    test_goal_bottom();
    test_game_over();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
